// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier for MULT/MULTU in the EX stage.
// Operands are reduced to magnitudes on accept, one multiplier bit is
// consumed per cycle LSB-first, and the sign is reapplied in a final
// fix-up cycle that also raises the one-cycle HiLo write strobe.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic                 hilo_we,
    output logic [2*WIDTH-1:0]   MulAns
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [2*WIDTH-1:0] PROD_ONE = (2*WIDTH)'(1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               neg;

    // Magnitude of an operand; the most-negative value maps to 2^(WIDTH-1)
    // because the result is read back as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(
        input logic signed [WIDTH-1:0] value,
        input logic                    isSigned
    );
        logic signed [WIDTH-1:0] negated;
        negated = -value;
        if (isSigned && value[WIDTH-1])
            return unsigned'(negated);
        return unsigned'(value);
    endfunction

    // Reapply the product sign as a full-width two's complement negation.
    function automatic logic [2*WIDTH-1:0] applySign(
        input logic [2*WIDTH-1:0] mag,
        input logic               isNeg
    );
        if (isNeg)
            return ~mag + PROD_ONE;
        return mag;
    endfunction

    assign hilo_we = done;

    // Control FSM plus shift-add datapath; reset clears every register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            MulAns       <= '0;
            cnt          <= '0;
            acc          <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
            neg          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        multiplicand <= {{WIDTH{1'b0}}, magnitude(signed'(dataA), signed_op)};
                        multiplier   <= magnitude(signed'(dataB), signed_op);
                        neg          <= signed_op & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                        acc          <= '0;
                        cnt          <= '0;
                        busy         <= 1'b1;
                        state        <= RUN;
                    end
                end
                // Accumulate one partial product per cycle, LSB of the multiplier first.
                RUN: begin
                    if (multiplier[cnt])
                        acc <= acc + (multiplicand << cnt);
                    cnt <= cnt + CNT_ONE;
                    if (cnt == LAST_BIT)
                        state <= FIX;
                end
                // Sign fix-up and result publication.
                FIX: begin
                    MulAns <= applySign(acc, neg);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
